uart_baud_gen: RTL and testbench

Programmable UART baud-rate generator: a parametrised successor to the fixed-constant UART clock divider. Divides `clk_in` by a runtime-loadable integer divisor with an optional fractional accumulator. Produces a single-cycle oversample strobe for the RX sampler, a single-cycle baud strobe for the TX shifter, and a 50 % duty `clk_out` at the baud rate. Sits between the system clock and the UART TX/RX datapaths.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_frac_acc.sv | 64 ++++++
 rtl/uart_baud_gen.sv | 180 ++++++++++++++++++
 tb/tb_uart_baud_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants for the UART blocks (baud generator, TX shifter, RX sampler).
// Keeping these in one place lets the TX and RX datapaths agree with the
// baud generator on the oversample ratio and the power-on divisor.
//
// Contents:
//   UART_CNT_W        width of the integer divisor and the cycle counter
//   UART_FRAC_W       width of the fractional divisor and its accumulator
//   UART_OVERSAMPLE   oversample ticks per baud period (even, >= 2)
//   UART_DEFAULT_DIV  divisor after reset: 100 MHz / (9600 * 16)
//   UART_DEFAULT_FRAC fractional divisor after reset: about 0.04 * 256
package uart_pkg;

  localparam int UART_CNT_W        = 16;
  localparam int UART_FRAC_W       = 8;
  localparam int UART_OVERSAMPLE   = 16;
  localparam int UART_DEFAULT_DIV  = 651;
  localparam int UART_DEFAULT_FRAC = 10;

endpackage

// File: rtl/uart_frac_acc.sv
// uart_frac_acc
// Fractional accumulator for the baud generator. On every terminal event of
// the integer counter the fractional divisor is added into the accumulator;
// the carry out becomes the stretch flag, which lengthens the next period by
// one clock. Over time the average period approaches div + frac / 2^FRAC_W.
//
// The whole module only exists when UART_BAUD_FRAC_EN is defined, so the
// default build carries no unreferenced module.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   clr_i      synchronous clear of accumulator and stretch flag
//   step_i     terminal event: accumulate frac_i
//   frac_i     fractional divisor currently in force
//   stretch_o  registered stretch flag for the period now running
`ifdef UART_BAUD_FRAC_EN
module uart_frac_acc
  import uart_pkg::*;
#(
  parameter int FRAC_W = UART_FRAC_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              stretch_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [FRAC_W:0]   sum;

  // Next accumulator state. A clear wins over a step; the carry of the
  // addition is remembered as the stretch flag for the following period.
  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, frac_i};
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (clr_i) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (step_i) begin
      acc_d     = sum[FRAC_W-1:0];
      stretch_d = sum[FRAC_W];
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q     <= '0;
      stretch_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
    end
  end

  assign stretch_o = stretch_q;

endmodule
`endif

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Programmable UART baud-rate generator. Divides clk_in by a runtime-loadable
// integer divisor (optionally with a fractional part) and produces:
//   tick_os    one-cycle oversample strobe for the RX sampler
//   tick_baud  one-cycle baud strobe, coincident with every OVERSAMPLE-th tick_os
//   clk_out    50 % duty square wave at the baud rate
//
// Ports:
//   clk_in     system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         generator enable; low clears the phase and applies a pending divisor
//   sync_clr   phase resynchronise (RX start-bit edge)
//   div_load   capture div_in/frac_in into the shadow registers
//   div_in     new integer divisor (0 and 1 behave as 2)
//   frac_in    new fractional divisor
//   div_pend   shadow loaded but not yet applied
//   tick_os, tick_baud, clk_out as above; all outputs are registered
//
// Build option: define UART_BAUD_FRAC_EN to compile in the fractional
// accumulator (uart_frac_acc). Without it frac_in is ignored and every
// period is exactly the effective integer divisor; the port list is the same.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CNT_W        = UART_CNT_W,
  parameter int FRAC_W       = UART_FRAC_W,
  parameter int OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int DEFAULT_DIV  = UART_DEFAULT_DIV,
  parameter int DEFAULT_FRAC = UART_DEFAULT_FRAC
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_load,
  input  logic [CNT_W-1:0]  div_in,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              div_pend,
  output logic              tick_os,
  output logic              tick_baud,
  output logic              clk_out
);

  localparam int               OS_W    = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] div_s_q, div_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_eff, term_val;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic             pend_q, pend_d;
  logic             tick_os_q, tick_os_d;
  logic             tick_baud_q, tick_baud_d;
  logic             clk_out_q, clk_out_d;
  logic             terminal;
  logic             apply;
  logic             step;
  logic             acc_clr;
  logic             stretch;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] frac_s_q, frac_s_d;

  // Fractional shadow and active registers follow the same capture/apply
  // timing as the integer divisor.
  always_comb begin
    frac_s_d = div_load ? frac_in : frac_s_q;
    frac_d   = apply ? frac_s_q : frac_q;
  end

  // Fractional divisor registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      frac_q   <= FRAC_W'(DEFAULT_FRAC);
      frac_s_q <= FRAC_W'(DEFAULT_FRAC);
    end else begin
      frac_q   <= frac_d;
      frac_s_q <= frac_s_d;
    end
  end

  uart_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk_i     (clk_in),
    .rst_ni    (rst_n),
    .clr_i     (acc_clr),
    .step_i    (step),
    .frac_i    (frac_q),
    .stretch_o (stretch)
  );
`else
  logic unused_frac;

  assign stretch     = 1'b0;
  assign unused_frac = ^{frac_in, FRAC_W'(DEFAULT_FRAC), step, acc_clr};
`endif

  // Next-state logic. Priority is en=0, then sync_clr, then normal counting.
  // The terminal compare uses >= so a counter that is somehow beyond the
  // terminal value still wraps instead of running the full counter range.
  // A pending shadow is applied on a terminal (or while disabled) before any
  // same-cycle load is captured, so such a load waits for the next terminal.
  always_comb begin
    div_eff     = (div_q < DIV_MIN) ? DIV_MIN : div_q;
    term_val    = div_eff - CNT_W'(1) + CNT_W'(stretch);
    terminal    = (cnt_q >= term_val);

    cnt_d       = cnt_q;
    os_cnt_d    = os_cnt_q;
    clk_out_d   = clk_out_q;
    tick_os_d   = 1'b0;
    tick_baud_d = 1'b0;
    step        = 1'b0;
    acc_clr     = 1'b0;
    apply       = 1'b0;

    if (!en) begin
      cnt_d     = '0;
      os_cnt_d  = '0;
      clk_out_d = 1'b0;
      acc_clr   = 1'b1;
      apply     = pend_q;
    end else if (sync_clr) begin
      cnt_d     = '0;
      os_cnt_d  = '0;
      clk_out_d = 1'b0;
      acc_clr   = 1'b1;
    end else if (terminal) begin
      cnt_d       = '0;
      tick_os_d   = 1'b1;
      step        = 1'b1;
      apply       = pend_q;
      tick_baud_d = (os_cnt_q == OS_LAST);
      os_cnt_d    = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
      if ((os_cnt_q == OS_LAST) || (os_cnt_q == OS_HALF)) begin
        clk_out_d = ~clk_out_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    div_s_d = div_load ? div_in : div_s_q;
    div_d   = apply ? div_s_q : div_q;
    pend_d  = div_load | (pend_q & ~apply);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= CNT_W'(DEFAULT_DIV);
      div_s_q     <= CNT_W'(DEFAULT_DIV);
      cnt_q       <= '0;
      os_cnt_q    <= '0;
      pend_q      <= 1'b0;
      tick_os_q   <= 1'b0;
      tick_baud_q <= 1'b0;
      clk_out_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      div_s_q     <= div_s_d;
      cnt_q       <= cnt_d;
      os_cnt_q    <= os_cnt_d;
      pend_q      <= pend_d;
      tick_os_q   <= tick_os_d;
      tick_baud_q <= tick_baud_d;
      clk_out_q   <= clk_out_d;
    end
  end

  assign div_pend  = pend_q;
  assign tick_os   = tick_os_q;
  assign tick_baud = tick_baud_q;
  assign clk_out   = clk_out_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen
// Self-checking bench for uart_baud_gen with OVERSAMPLE = 4. A behavioural
// model tracks the generator in terms of "cycles left in this period" and
// "ticks since the phase was cleared"; expected outputs follow from those.
module tb_uart_baud_gen;

  localparam int OS = 4;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
`else
  localparam bit FRAC_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync_clr;
  logic        div_load;
  logic [15:0] div_in;
  logic [7:0]  frac_in;
  logic        div_pend;
  logic        tick_os;
  logic        tick_baud;
  logic        clk_out;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int   mDiv, mFrac, mShDiv, mShFrac, mAcc, mLeft, mTicks;
  bit   mPend, mStretch;
  logic expTickOs, expTickBaud, expClk, expPend;

  uart_baud_gen #(
    .CNT_W        (16),
    .FRAC_W       (8),
    .OVERSAMPLE   (OS),
    .DEFAULT_DIV  (651),
    .DEFAULT_FRAC (10)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .sync_clr  (sync_clr),
    .div_load  (div_load),
    .div_in    (div_in),
    .frac_in   (frac_in),
    .div_pend  (div_pend),
    .tick_os   (tick_os),
    .tick_baud (tick_baud),
    .clk_out   (clk_out)
  );

  always #5 clk_in = ~clk_in;

  // Single comparison point: counts every vector and reports mismatches
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %b, expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int effDiv(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  // Phase clear: a fresh period of the effective divisor starts next cycle
  task automatic clearPhase();
    mAcc        = 0;
    mStretch    = 1'b0;
    mTicks      = 0;
    mLeft       = effDiv(mDiv);
    expTickOs   = 1'b0;
    expTickBaud = 1'b0;
    expClk      = 1'b0;
  endtask

  task automatic modelReset();
    mDiv    = 651;
    mFrac   = 10;
    mShDiv  = 651;
    mShFrac = 10;
    mPend   = 1'b0;
    clearPhase();
    expPend = 1'b0;
  endtask

  // Advance the model by one rising edge with the given inputs
  task automatic modelStep(input bit e, input bit s, input bit l, input int d, input int f);
    expTickOs   = 1'b0;
    expTickBaud = 1'b0;
    if (!e) begin
      if (mPend) begin
        mDiv  = mShDiv;
        mFrac = mShFrac;
      end
      mPend = l;
      if (l) begin
        mShDiv  = d;
        mShFrac = f;
      end
      clearPhase();
    end else if (s) begin
      if (l) begin
        mShDiv  = d;
        mShFrac = f;
        mPend   = 1'b1;
      end
      clearPhase();
    end else begin
      mLeft--;
      if (mLeft == 0) begin
        mTicks++;
        expTickOs   = 1'b1;
        expTickBaud = ((mTicks % OS) == 0);
        expClk      = ((mTicks % OS) >= OS / 2);
        if (FRAC_EN) begin
          mAcc     = mAcc + mFrac;
          mStretch = (mAcc >= 256);
          mAcc     = mAcc % 256;
        end
        if (mPend) begin
          mDiv  = mShDiv;
          mFrac = mShFrac;
        end
        mPend = l;
        if (l) begin
          mShDiv  = d;
          mShFrac = f;
        end
        mLeft = effDiv(mDiv) + int'(mStretch);
      end else if (l) begin
        mShDiv  = d;
        mShFrac = f;
        mPend   = 1'b1;
      end
    end
    expPend = mPend;
  endtask

  // Drive one cycle of inputs, step the model on the edge, check on the negedge
  task automatic applyStimulus(input bit e, input bit s, input bit l, input int d, input int f);
    en       = e;
    sync_clr = s;
    div_load = l;
    div_in   = 16'(d);
    frac_in  = 8'(f);
    @(posedge clk_in);
    modelStep(e, s, l, d, f);
    @(negedge clk_in);
    checkOutput("tick_os", tick_os, expTickOs);
    checkOutput("tick_baud", tick_baud, expTickBaud);
    checkOutput("clk_out", clk_out, expClk);
    checkOutput("div_pend", div_pend, expPend);
  endtask

  task automatic runCycles(input int n, input int d, input int f);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, d, f);
  endtask

  // Asynchronous reset between edges: outputs must drop before any clock edge
  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_tick_os", tick_os, 1'b0);
    checkOutput("async_rst_tick_baud", tick_baud, 1'b0);
    checkOutput("async_rst_clk_out", clk_out, 1'b0);
    checkOutput("async_rst_div_pend", div_pend, 1'b0);
    en       = 1'b0;
    sync_clr = 1'b0;
    div_load = 1'b0;
    modelReset();
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    sync_clr = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    frac_in  = '0;
    modelReset();
    $display("[TB] uart_baud_gen bench, fractional build = %0d", FRAC_EN);
    @(negedge clk_in);
    @(negedge clk_in);
    checkOutput("reset_tick_os", tick_os, 1'b0);
    checkOutput("reset_tick_baud", tick_baud, 1'b0);
    checkOutput("reset_clk_out", clk_out, 1'b0);
    checkOutput("reset_div_pend", div_pend, 1'b0);
    rst_n = 1'b1;

    // Divisor 4, no fraction: loaded while disabled, then free-running
    applyStimulus(1'b0, 1'b0, 1'b1, 4, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4, 0);
    runCycles(40, 4, 0);

    // Divisor 4 with half-cycle fraction
    applyStimulus(1'b0, 1'b0, 1'b1, 4, 128);
    applyStimulus(1'b0, 1'b0, 1'b0, 4, 128);
    runCycles(40, 4, 128);

    // Mid-period load of divisor 6
    applyStimulus(1'b0, 1'b0, 1'b1, 4, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4, 0);
    runCycles(2, 4, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 6, 0);
    runCycles(30, 6, 0);

    // Load coincident with a terminal event
    for (int k = 0; k < 20 && mLeft != 1; k++) applyStimulus(1'b1, 1'b0, 1'b0, 4, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4, 0);
    runCycles(30, 4, 0);

    // Divisors 0 and 1 behave as 2
    applyStimulus(1'b1, 1'b0, 1'b1, 0, 0);
    runCycles(20, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1, 0);
    runCycles(20, 1, 0);

    // Phase resynchronise mid-period
    applyStimulus(1'b1, 1'b0, 1'b1, 5, 0);
    runCycles(13, 5, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 5, 0);
    runCycles(20, 5, 0);

    // Disable with a pending load: pending clears on the next edge
    runCycles(2, 5, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3, 0);
    runCycles(20, 3, 0);

    // Asynchronous reset mid-period, then the default divisor again
    runCycles(1, 3, 0);
    pulseReset();
    runCycles(660, 3, 0);

    // Randomised traffic with small divisors
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 0);
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    ($urandom_range(0, 49) == 0),
                    ($urandom_range(0, 29) == 0),
                    int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
